// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage MIPS32 pipeline.
// Combines load-use detection, taken-branch flushing, a divider hand-shake FSM,
// and a data-memory wait hold with timeout, plus a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_branch_taken,
    input  logic             ex_mem_rd,
    input  logic [4:0]       ex_waddr,
    input  logic             ex_div_start,
    input  logic             div_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             div_go,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [TMO_W-1:0] TMO_VAL = TMO_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t       state;
    div_state_t       next_state;
    logic [TMO_W-1:0] wait_cnt;
    logic             lu;
    logic             mh;
    logic             db;
    logic             start_div;
    logic             hold_front;

    // Hazard detection, divider next-state, and all stall/flush outputs (gated off during reset)
    always_comb begin
        next_state = state;
        db         = 1'b0;
        start_div  = 1'b0;

        lu = ex_mem_rd && (ex_waddr != 5'd0) &&
             ((id_rs_used && (id_rs == ex_waddr)) || (id_rt_used && (id_rt == ex_waddr)));
        mh = mem_req && !mem_ack && (wait_cnt != TMO_VAL);

        case (state)
            IDLE: begin
                if (ex_div_start) begin
                    db = 1'b1;
                    if (!mh) begin
                        next_state = DIV_BUSY;
                        start_div  = 1'b1;
                    end
                end
            end
            DIV_BUSY: begin
                db = 1'b1;
                if (div_done) begin
                    next_state = mh ? DIV_DONE : IDLE;
                end
            end
            DIV_DONE: begin
                db = mh;
                if (!mh) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        hold_front   = mh || db || lu;
        stall_pc     = !rst && hold_front;
        stall_if_id  = !rst && hold_front;
        stall_id_ex  = !rst && (mh || db);
        stall_ex_mem = !rst && mh;
        flush_mem_wb = !rst && mh;
        flush_ex_mem = !rst && db && !mh;
        flush_id_ex  = !rst && lu && !mh && !db;
        flush_if_id  = !rst && id_branch_taken && !hold_front;
        div_go       = !rst && start_div;
    end

    // Divider sequencing state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory wait counter; on reaching the timeout the hold is dropped and a sticky error is raised
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else if (mem_req && !mem_ack) begin
            if (wait_cnt == TMO_VAL) begin
                wait_cnt <= '0;
                bus_err  <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + TMO_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Performance counter of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_pc) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by random stimulus, all checked
// against a cycle-level behavioural model of the hazard controller.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       br;
        logic       ld;
        logic [4:0] waddr;
        logic       div_start;
        logic       div_done;
        logic       mem_req;
        logic       mem_ack;
    } stim_t;

    logic        clk = 1'b0;
    stim_t       cur;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic        div_go, bus_err;
    logic [31:0] stall_cycles;

    int          n_asserts = 0;
    int          n_fail    = 0;

    // Reference model state: 0 = no division, 1 = divider running, 2 = result waiting on memory
    int          phase     = 0;
    int          wait_n    = 0;
    logic        m_err     = 1'b0;
    logic [31:0] m_cnt     = '0;
    bit          m_known   = 1'b0;

    // Free-running clock
    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TMO_W(8), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(cur.rst),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_rs_used(cur.rs_used), .id_rt_used(cur.rt_used),
        .id_branch_taken(cur.br), .ex_mem_rd(cur.ld), .ex_waddr(cur.waddr),
        .ex_div_start(cur.div_start), .div_done(cur.div_done),
        .mem_req(cur.mem_req), .mem_ack(cur.mem_ack),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb), .div_go(div_go),
        .bus_err(bus_err), .stall_cycles(stall_cycles)
    );

    function automatic bit model_mh(input stim_t s);
        return s.mem_req && !s.mem_ack && (wait_n != TMO);
    endfunction

    // Expected {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, div_go}
    function automatic logic [8:0] expected_ctrl(input stim_t s);
        bit lu, mh, db, hold;
        lu = s.ld && (s.waddr != 0) &&
             ((s.rs_used && s.rs == s.waddr) || (s.rt_used && s.rt == s.waddr));
        mh = model_mh(s);
        db = (phase == 0 && s.div_start) || (phase == 1) || (phase == 2 && mh);
        hold = mh || db || lu;
        if (s.rst) return 9'b0;
        return {hold, hold, mh || db, mh, s.br && !hold, lu && !mh && !db,
                db && !mh, mh, phase == 0 && s.div_start && !mh};
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [8:0] obs;
        obs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_ex_mem, flush_mem_wb, div_go};
        check1({tag, ".ctrl"}, {23'b0, obs}, {23'b0, expected_ctrl(cur)});
        if (m_known) begin
            check1({tag, ".bus_err"}, {31'b0, bus_err}, {31'b0, m_err});
            check1({tag, ".stall_cycles"}, stall_cycles, m_cnt);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge and check at the falling edge
    task automatic applyStimulus(input stim_t s, input string tag);
        cur = s;
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Take the rising edge and advance the reference model with the inputs of that cycle
    task automatic advance();
        bit mh;
        bit stall;
        @(posedge clk);
        mh    = model_mh(cur);
        stall = expected_ctrl(cur)[8];
        if (cur.rst) begin
            phase = 0; wait_n = 0; m_err = 1'b0; m_cnt = '0; m_known = 1'b1;
        end else begin
            if (stall) m_cnt = m_cnt + 1;
            if (cur.mem_req && !cur.mem_ack) begin
                if (wait_n == TMO) begin wait_n = 0; m_err = 1'b1; end
                else wait_n = wait_n + 1;
            end else begin
                wait_n = 0;
            end
            case (phase)
                0: if (cur.div_start && !mh) phase = 1;
                1: if (cur.div_done) phase = mh ? 2 : 0;
                default: if (!mh) phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic step(input stim_t s, input string tag);
        applyStimulus(s, tag);
        advance();
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Directed scenarios, then random traffic
    initial begin
        stim_t s;
        cur = quiet();
        cur.rst = 1'b1;
        #1;

        s = quiet(); s.rst = 1'b1;
        step(s, "reset0");
        step(s, "reset1");

        s = quiet(); s.ld = 1'b1; s.waddr = 5'd5; s.rs = 5'd5; s.rs_used = 1'b1;
        applyStimulus(s, "loaduse");
        check1("loaduse.flush_id_ex", {31'b0, flush_id_ex}, 32'd1);
        advance();
        s.waddr = 5'd0; s.rs = 5'd0;
        applyStimulus(s, "loaduse_r0");
        check1("loaduse_r0.stall_pc", {31'b0, stall_pc}, 32'd0);
        advance();

        s = quiet(); s.br = 1'b1;
        applyStimulus(s, "branch");
        check1("branch.flush_if_id", {31'b0, flush_if_id}, 32'd1);
        advance();
        s.ld = 1'b1; s.waddr = 5'd9; s.rt = 5'd9; s.rt_used = 1'b1;
        step(s, "branch_lu");

        s = quiet(); s.rst = 1'b1;
        step(s, "reset_div");
        s = quiet(); s.div_start = 1'b1;
        applyStimulus(s, "div0");
        check1("div0.div_go", {31'b0, div_go}, 32'd1);
        advance();
        s = quiet();
        for (int i = 1; i < 4; i++) step(s, "div_busy");
        s.div_done = 1'b1;
        step(s, "div_done");
        s = quiet();
        applyStimulus(s, "div_after");
        check1("div_after.stall_pc", {31'b0, stall_pc}, 32'd0);
        check1("div_after.stall_cycles", stall_cycles, 32'd5);
        advance();

        s = quiet(); s.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step(s, "memwait");
        s.mem_ack = 1'b1;
        step(s, "memack");

        s = quiet(); s.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step(s, "tmo_hold");
        applyStimulus(s, "tmo_release");
        check1("tmo_release.stall_ex_mem", {31'b0, stall_ex_mem}, 32'd0);
        advance();
        s = quiet();
        applyStimulus(s, "tmo_err");
        check1("tmo_err.bus_err", {31'b0, bus_err}, 32'd1);
        advance();
        step(s, "tmo_sticky");

        s = quiet(); s.rst = 1'b1;
        step(s, "reset_ddone");
        s = quiet(); s.div_start = 1'b1;
        step(s, "dd_start");
        s = quiet(); s.div_done = 1'b1; s.mem_req = 1'b1;
        step(s, "dd_done_mh");
        s = quiet(); s.mem_req = 1'b1;
        applyStimulus(s, "dd_hold");
        check1("dd_hold.stall_id_ex", {31'b0, stall_id_ex}, 32'd1);
        advance();
        s.mem_ack = 1'b1;
        step(s, "dd_ack");
        s = quiet();
        step(s, "dd_idle");

        s = quiet(); s.div_start = 1'b1;
        step(s, "rb_start");
        s = quiet(); s.rst = 1'b1;
        step(s, "rb_reset");
        s = quiet();
        applyStimulus(s, "rb_after");
        check1("rb_after.stall_pc", {31'b0, stall_pc}, 32'd0);
        advance();

        for (int i = 0; i < 400; i++) begin
            s = quiet();
            s.rst       = ($urandom_range(63) == 0);
            s.rs        = 5'($urandom_range(3));
            s.rt        = 5'($urandom_range(3));
            s.rs_used   = 1'($urandom_range(1));
            s.rt_used   = 1'($urandom_range(1));
            s.br        = ($urandom_range(3) == 0);
            s.ld        = 1'($urandom_range(1));
            s.waddr     = 5'($urandom_range(3));
            s.div_start = ($urandom_range(7) == 0);
            s.div_done  = ($urandom_range(5) == 0);
            s.mem_req   = ($urandom_range(2) == 0);
            s.mem_ack   = 1'($urandom_range(1));
            step(s, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
